// File: rtl/func_inverse_search.sv
// func_inverse_search: inverse lookup on a monotonic non-decreasing table.
// Returns the largest index z with func(z) <= target. It does this by a
// successive-approximation search that drives the shared table index port.
// Optional macro INV_ROUND_EN adds a ROUND cycle. That cycle picks the nearer
// of z and z+1, and ties keep the lower index.
module func_inverse_search #(
  parameter int AW = 8,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] target,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] z_out,
  output logic          exact,
  output logic          under
);

  localparam int KW = (AW > 1) ? $clog2(AW) : 1;
  localparam logic [AW-1:0] ONE = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_ROUND, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cand_q, cand_d;
  logic [DW-1:0] fz_q, fz_d;
  logic [DW-1:0] tgt_q, tgt_d;
  logic [KW-1:0] k_q, k_d;
  logic          under_q, under_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] z_q, z_d;
  logic          exact_q, exact_d;
  logic [AW-1:0] probe;

  assign probe     = cand_q | (ONE << k_q);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign z_out     = z_q;
  assign exact     = exact_q;
  assign under     = under_q;

  // Table index: the trial index while searching, cand+1 while rounding, else 0.
  always_comb begin
    rom_addr = '0;
    case (state_q)
      S_SEARCH: rom_addr = probe;
      S_ROUND:  rom_addr = cand_q + ONE;
      default:  rom_addr = '0;
    endcase
  end

  // Next-state and next-output computation for the search FSM.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    fz_d        = fz_q;
    tgt_d       = tgt_q;
    k_d         = k_q;
    under_d     = under_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    z_d         = z_q;
    exact_d     = exact_q;
    case (state_q)
      S_IDLE: begin
        // rom_addr is 0 here, so rom_data is func(0).
        if (in_valid) begin
          tgt_d      = target;
          under_d    = rom_data > target;
          fz_d       = rom_data;
          cand_d     = '0;
          k_d        = KW'(AW - 1);
          in_ready_d = 1'b0;
          state_d    = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (rom_data <= tgt_q) begin
          cand_d = probe;
          fz_d   = rom_data;
        end
        if (k_q == '0) begin
`ifdef INV_ROUND_EN
          state_d     = S_ROUND;
`else
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          z_d         = under_q ? '0 : cand_d;
          exact_d     = (fz_d == tgt_q) && !under_q;
`endif
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      S_ROUND: begin
        // When cand < max, cand is the floor, so func(cand+1) > target and
        // func(cand) <= target. Both differences are therefore non-negative.
        state_d     = S_DONE;
        out_valid_d = 1'b1;
        z_d         = under_q ? '0 : cand_q;
        exact_d     = (fz_q == tgt_q) && !under_q;
        if (cand_q != '1 && !under_q &&
            (rom_data - tgt_q) < (tgt_q - fz_q)) begin
          cand_d  = cand_q + ONE;
          z_d     = cand_q + ONE;
          fz_d    = rom_data;
          exact_d = (rom_data == tgt_q);
        end
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  // State and registered outputs. Reset aborts any search in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cand_q      <= '0;
      fz_q        <= '0;
      tgt_q       <= '0;
      k_q         <= '0;
      under_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      exact_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      fz_q        <= fz_d;
      tgt_q       <= tgt_d;
      k_q         <= k_d;
      under_q     <= under_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      exact_q     <= exact_d;
    end
  end

endmodule

// File: tb/tb_func_inverse_search.sv
// Bench for func_inverse_search. It uses a behavioural monotonic table, an
// exhaustive-scan reference model and a scoreboard queue of expected results.
module tb_func_inverse_search;

`ifdef INV_ROUND_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif

  logic        clk = 0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] target;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  z_out;
  logic        exact;
  logic        under;

  logic [11:0] rom_tab [0:255];

  typedef struct {
    logic [7:0] z;
    logic       ex;
    logic       un;
  } exp_t;
  exp_t sbq[$];

  int n_chk = 0;
  int n_err = 0;

  func_inverse_search dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .target(target), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .z_out(z_out),
    .exact(exact), .under(under)
  );

  always #5 clk = ~clk;
  assign rom_data = rom_tab[rom_addr];

  // Piecewise table with anchor points chosen so the documented cases hold.
  function automatic logic [11:0] fval(int z);
    if (z <= 163)      return 12'd2;
    else if (z <= 216) return 12'(3 + ((z - 164) * 89) / 52);
    else if (z <= 240) return 12'(101 + ((z - 217) * 560) / 23);
    else if (z <= 246) return 12'(661 + ((z - 240) * 377) / 6);
    else               return 12'(1038 + ((z - 246) * 886) / 9);
  endfunction

  // Reference: linear scan for the floor, then optional nearest rounding.
  function automatic exp_t model(logic [11:0] t);
    exp_t e;
    int z = -1;
    for (int i = 0; i < 256; i++) if (rom_tab[i] <= t) z = i;
    e.un = (z < 0);
    if (e.un) begin
      e.z = 0; e.ex = 0;
    end else begin
`ifdef INV_ROUND_EN
      if (z < 255 && (int'(rom_tab[z+1]) - int'(t)) < (int'(t) - int'(rom_tab[z]))) z = z + 1;
`endif
      e.z  = 8'(z);
      e.ex = (rom_tab[z] == t);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  // Present one request and wait for it to be accepted; optionally score it.
  task automatic start(input logic [11:0] t, input bit push);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1; target = t;
    if (push) sbq.push_back(model(t));
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; target = 12'($urandom);
  endtask

  // Wait for the result (at cycle 1 after accept), check latency and values,
  // optionally stall the consumer, then complete the transfer.
  task automatic finish(input int hold, input bit chk_addr);
    exp_t e;
    int cyc = 1;
    while (!out_valid && cyc < 30) begin
      if (chk_addr && cyc <= 8) chk("rom_addr_seq", rom_addr, 32'd128 >> (cyc - 1));
      @(negedge clk); cyc++;
    end
    chk("latency", cyc, LAT);
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk("z_out", z_out, e.z);
    chk("exact", exact, e.ex);
    chk("under", under, e.un);
    chk("done_addr", rom_addr, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); target = 12'($urandom);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_z", z_out, e.z);
      chk("hold_exact", exact, e.ex);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    chk("xfer_valid", out_valid, 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_z"}, z_out, 0);
    chk({tag, "_exact"}, exact, 0);
    chk({tag, "_under"}, under, 0);
    chk({tag, "_addr"}, rom_addr, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_tab[i] = fval(i);
    reset = 1; in_valid = 0; target = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    check_idle("rst");
    reset = 0;
    @(negedge clk);
    check_idle("post_rst");

    start(12'd2, 1);    finish(0, 0);
    start(12'd1, 1);    finish(0, 1);
    start(12'd100, 1);  finish(0, 0);
    start(12'd1924, 1); finish(0, 0);
    start(12'd4095, 1); finish(0, 0);
    start(12'd500, 1);  finish(5, 0);
    start(12'd1038, 1); finish(0, 0);

    // Abort mid-search: reset at search step 4, the request is dropped.
    start(12'd300, 0);
    repeat (3) @(negedge clk);
    reset = 1;
    #1;
    check_idle("abort");
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check_idle("abort_idle");
    start(12'd661, 1);  finish(0, 0);

    for (int r = 0; r < 6; r++) begin
      start(12'($urandom_range(0, 2047)), 1);
      finish(r % 3, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
